// File: rtl/pingpong_bank_ctrl.sv
// -----------------------------------------------------------------------------
// pingpong_bank_ctrl
//
// Controller for a two-bank (ping-pong) RAM pair. A producer fills one bank
// while a consumer drains the other. Banks change hands only when a whole
// bank has been written or read, so the reader never sees a partial frame.
// The block drives every RAM enable/address and returns read data one cycle
// after the read is accepted.
//
// Ports:
//   clk, resetn               system clock, synchronous active-low reset
//   wr_valid, wr_data         producer word
//   wr_ready                  current write bank can accept a word
//   wr_overflow               1-cycle pulse: word offered while not ready, dropped
//   rd_req                    consumer asks for the next word
//   rd_ready                  current read bank holds a complete frame
//   rd_data, rd_valid,        returned word, its strobe, and a flag marking the
//   rd_last                   final word (address DEPTH-1) of its bank
//   ram{0,1}_we/_waddr/_wdata write port of each bank
//   ram{0,1}_re/_raddr        read port of each bank
//   ram{0,1}_rdata            bank read data, registered inside the RAM
//   bank_full                 per-bank full flag, bit n = bank n
//   swap_pulse                1-cycle pulse when the write side changes bank
// -----------------------------------------------------------------------------
module pingpong_bank_ctrl #(
    parameter int DW    = 8,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          resetn,

    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    output logic          wr_overflow,

    input  logic          rd_req,
    output logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          rd_last,

    output logic          ram0_we,
    output logic [AW-1:0] ram0_waddr,
    output logic [DW-1:0] ram0_wdata,
    output logic          ram1_we,
    output logic [AW-1:0] ram1_waddr,
    output logic [DW-1:0] ram1_wdata,

    output logic          ram0_re,
    output logic [AW-1:0] ram0_raddr,
    output logic          ram1_re,
    output logic [AW-1:0] ram1_raddr,
    input  logic [DW-1:0] ram0_rdata,
    input  logic [DW-1:0] ram1_rdata,

    output logic [1:0]    bank_full,
    output logic          swap_pulse
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    // Architectural state
    logic          r_wr_bank;
    logic          r_rd_bank;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [1:0]    r_bank_full;
    logic          r_wr_overflow;
    logic          r_swap_pulse;

    // Read-return pipeline: which bank was read and whether it was the last word
    logic          r_rd_valid;
    logic          r_rd_last;
    logic          r_rd_sel;

    logic          w_wr_ready;
    logic          w_rd_ready;
    logic          w_wr_accept;
    logic          w_rd_accept;
    logic          w_wr_done;
    logic          w_rd_done;
    logic [1:0]    w_full_set;
    logic [1:0]    w_full_clr;

    assign w_wr_ready  = ~r_bank_full[r_wr_bank];
    assign w_rd_ready  = r_bank_full[r_rd_bank];

    // NOTE: accepts are qualified with resetn so no RAM enable can fire in a
    // reset cycle, even though the registered state is still stale then.
    assign w_wr_accept = wr_valid & w_wr_ready & resetn;
    assign w_rd_accept = rd_req   & w_rd_ready & resetn;
    assign w_wr_done   = w_wr_accept & (r_wr_ptr == LAST_ADDR);
    assign w_rd_done   = w_rd_accept & (r_rd_ptr == LAST_ADDR);

    // A write can only complete on a non-full bank and a read only on a full
    // one, so set and clear never target the same bit in the same cycle.
    assign w_full_set  = {w_wr_done &  r_wr_bank, w_wr_done & ~r_wr_bank};
    assign w_full_clr  = {w_rd_done &  r_rd_bank, w_rd_done & ~r_rd_bank};

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_bank     <= 1'b0;
            r_rd_bank     <= 1'b0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_bank_full   <= 2'b00;
            r_wr_overflow <= 1'b0;
            r_swap_pulse  <= 1'b0;
            r_rd_valid    <= 1'b0;
            r_rd_last     <= 1'b0;
            r_rd_sel      <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                // DEPTH is a power of two, so the increment wraps by itself
                r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_wr_done) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end

            if (w_rd_accept) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_rd_sel <= r_rd_bank;
                if (w_rd_done) begin
                    r_rd_bank <= ~r_rd_bank;
                end
            end

            r_bank_full   <= (r_bank_full | w_full_set) & ~w_full_clr;
            r_swap_pulse  <= w_wr_done;
            r_wr_overflow <= wr_valid & ~w_wr_ready;
            r_rd_valid    <= w_rd_accept;
            r_rd_last     <= w_rd_done;
        end
    end

    // RAM write ports: only the current write bank is enabled
    assign ram0_we    = w_wr_accept & ~r_wr_bank;
    assign ram1_we    = w_wr_accept &  r_wr_bank;
    assign ram0_waddr = r_wr_ptr;
    assign ram1_waddr = r_wr_ptr;
    assign ram0_wdata = wr_data;
    assign ram1_wdata = wr_data;

    // RAM read ports: only the current read bank is enabled
    assign ram0_re    = w_rd_accept & ~r_rd_bank;
    assign ram1_re    = w_rd_accept &  r_rd_bank;
    assign ram0_raddr = r_rd_ptr;
    assign ram1_raddr = r_rd_ptr;

    // The RAM already registers its output, so the return path is a mux on the
    // registered bank index; it reads as zero whenever no word is being returned.
    assign rd_data     = r_rd_valid ? (r_rd_sel ? ram1_rdata : ram0_rdata) : '0;
    assign rd_valid    = r_rd_valid;
    assign rd_last     = r_rd_last;

    assign wr_ready    = w_wr_ready;
    assign rd_ready    = w_rd_ready;
    assign wr_overflow = r_wr_overflow;
    assign swap_pulse  = r_swap_pulse;
    assign bank_full   = r_bank_full;

endmodule

// File: doc/pingpong_bank_ctrl.md
Name: pingpong_bank_ctrl

Overview:
Controller for the two-bank (ping-pong) RAM pair behind the VGA/game data path. A producer fills one bank while a consumer drains the other. Banks swap only on completion, so the reader never sees a partially written buffer. The block owns all RAM enables and addresses, tracks per-bank full status, and returns read data with a fixed latency.

Parameters:
DW, 8, data width of each RAM word
DEPTH, 32, words per bank; must be a power of two, at least 2
AW, 5, address width, equal to log2(DEPTH)

Ports:
clk  in  1  single system clock, all logic on rising edge
resetn  in  1  synchronous active-low reset
wr_valid  in  1  producer presents wr_data this cycle
wr_data  in  DW  producer word
wr_ready  out  1  current write bank accepts a word
wr_overflow  out  1  one-cycle pulse: wr_valid seen while wr_ready=0, word dropped
rd_req  in  1  consumer requests next word
rd_ready  out  1  current read bank holds a complete frame
rd_data  out  DW  returned word
rd_valid  out  1  rd_data valid this cycle
rd_last  out  1  with rd_valid: word is the final one (address DEPTH-1) of its bank
ram0_we, ram1_we  out  1  bank write enable
ram0_waddr, ram1_waddr  out  AW  bank write address
ram0_wdata, ram1_wdata  out  DW  bank write data
ram0_re, ram1_re  out  1  bank read enable
ram0_raddr, ram1_raddr  out  AW  bank read address
ram0_rdata, ram1_rdata  in  DW  bank read data, registered inside the RAM (1-cycle latency)
bank_full  out  2  per-bank full flag; bit n = bank n
swap_pulse  out  1  one-cycle pulse when the write side switches banks

Behaviour:
- Reset (synchronous, resetn=0 at a clock edge) sets: wr_bank=0, rd_bank=0, wr_ptr=0, rd_ptr=0, bank_full=00, rd_valid=0, rd_last=0, wr_overflow=0, swap_pulse=0, rd_data=0. All RAM enables are forced to 0 during reset. Reset mid-frame discards all contents; there is no resume.
- wr_ready = !bank_full[wr_bank] (combinational).
- rd_ready = bank_full[rd_bank] (combinational).
- Write accept: wr_valid and wr_ready in the same cycle.
  - Same cycle: ram{wr_bank}_we=1, waddr=wr_ptr, wdata=wr_data. The other bank's we=0.
  - Clock edge: wr_ptr increments.
- Write completion: on accepting the word with wr_ptr=DEPTH-1:
  - wr_ptr wraps to 0.
  - bank_full[wr_bank] is set.
  - wr_bank toggles.
  - swap_pulse is 1 for the next cycle.
- Write refused: wr_valid with wr_ready=0 writes nothing. wr_overflow is 1 for the next cycle.
- Read accept: rd_req and rd_ready in the same cycle.
  - Same cycle: ram{rd_bank}_re=1, raddr=rd_ptr.
  - Clock edge: rd_ptr increments. The bank index and a last flag (rd_ptr==DEPTH-1) are registered.
- Read completion: on accepting the read with rd_ptr=DEPTH-1:
  - rd_ptr wraps to 0.
  - bank_full[rd_bank] clears.
  - rd_bank toggles.
- Read request refused (rd_ready=0): no RAM access; rd_valid stays 0.
- Read return latency: exactly 1 cycle after accept.
  - rd_valid=1 and rd_data = ramX_rdata, with X = the registered bank index.
  - rd_last = the registered last flag.
  - Back-to-back reads give one word per cycle.
- Simultaneous events:
  - Write completion on bank A and read completion on bank B in the same cycle are independent; both take effect.
  - Write completion and read completion on the same bank in one cycle cannot occur: the write needs !full, the read needs full.
  - A bank whose full flag is set in cycle N can be read from cycle N+1.
  - Reading bank A while writing bank B is legal every cycle.
- Both banks full: wr_ready=0 until the reader finishes a bank. The freed bank is then the next write bank, because wr_bank already points to it.
- A bank is never written while full, and never read while not full.

Test Plan:
1. Reset, then write 32 words (values 0x00..0x1F) with wr_valid held high → bank_full=01, swap_pulse one cycle after the 32nd write, wr_bank=1, rd_ready=1.
2. From scenario 1, hold rd_req for 32 cycles → rd_valid 1 cycle after each request, rd_data 0x00..0x1F in order, rd_last only with 0x1F, bank_full=00 afterwards, rd_bank=1.
3. Write 64 words without reading → bank_full=11, wr_ready=0. A 65th wr_valid gives wr_overflow=1 for one cycle, and RAM contents are unchanged.
4. Concurrent streaming: bank0 full, read bank0 while writing 0x40..0x5F into bank1 every cycle → both completions occur in the same cycle, bank_full goes 01→10, no overflow.
5. rd_req while bank_full=00 → no ram_re, rd_valid stays 0, rd_ptr stays 0.
6. Assert resetn=0 after 10 writes and 5 reads → next cycle all flags, pointers and pulses are 0. A subsequent write lands at bank0 address 0.
